// File: rtl/dfswt_sequencer.sv
// Event-triggered clear/fill/settle/report/cooldown controller in front of a dfswt instance.
// Defining DFSWT_SEQ_STATS_EN adds the saturating missed_events counter port.
module dfswt_sequencer #(
  parameter int WINDOW   = 128,
  parameter int CNT_W    = 7,
  parameter int BIN_W    = 6,
  parameter int SETTLE   = 2,
  parameter int COOLDOWN = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic             event_detected,
  input  logic [BIN_W-1:0] freqbin_in,
  output logic             dft_enable,
  output logic             dft_clear,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
`ifdef DFSWT_SEQ_STATS_EN
  output logic [7:0]       missed_events,
`endif
  output logic [BIN_W-1:0] result_bin
);

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, WAIT, REPORT, COOL} state_t;

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;
  logic             accept;

  assign accept     = result_valid && result_ready;
  assign dft_clear  = (state == CLEAR);
  assign dft_enable = (state == FILL) && sample_valid;

  // One counter is shared by FILL (strobes), WAIT (cycles) and COOL (strobes).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE:  if (event_detected && sample_valid) state_nxt = CLEAR;
      CLEAR: state_nxt = FILL;
      FILL: begin
        if (sample_valid) begin
          if (cnt == WIN_LAST) begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (cnt == SET_LAST) begin
          cnt_nxt   = '0;
          capture   = 1'b1;
          state_nxt = REPORT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REPORT: if (accept) state_nxt = (COOLDOWN == 0) ? IDLE : COOL;
      COOL: begin
        if (sample_valid) begin
          if (cnt == COOL_LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_bin   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
      if (capture) begin
        result_valid <= 1'b1;
        result_bin   <= freqbin_in;
      end else if (accept) begin
        result_valid <= 1'b0;
      end
    end
  end

`ifdef DFSWT_SEQ_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      missed_events <= '0;
    end else if ((state != IDLE) && event_detected && sample_valid && (missed_events != 8'hFF)) begin
      missed_events <= missed_events + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dfswt_sequencer.sv
// Bench for dfswt_sequencer: per-cycle comparison against a countdown reference model,
// a table of full analysis transactions, hand-written corner sequences and random traffic.
module tb_dfswt_sequencer;
  localparam int WINDOW = 128, SETTLE = 2, COOLDOWN = 16;

  logic       clock = 1'b0, reset = 1'b0;
  logic       sample_valid = 1'b0, event_detected = 1'b0, result_ready = 1'b0;
  logic [5:0] freqbin_in = '0;
  logic       dft_enable, dft_clear, busy, result_valid;
  logic [5:0] result_bin;
`ifdef DFSWT_SEQ_STATS_EN
  logic [7:0] missed_events;
  int         m_missed, s_missed;
`endif

  dfswt_sequencer #(.WINDOW(WINDOW), .CNT_W(7), .BIN_W(6), .SETTLE(SETTLE), .COOLDOWN(COOLDOWN)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .event_detected(event_detected),
    .freqbin_in(freqbin_in), .dft_enable(dft_enable), .dft_clear(dft_clear), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
`ifdef DFSWT_SEQ_STATS_EN
    .missed_events(missed_events),
`endif
    .result_bin(result_bin)
  );

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0, cyc_n = 0;

  // Reference model: remaining-work countdowns rather than a state machine.
  int         m_fill, m_settle, m_cool;
  bit         m_clr, m_rep;
  logic [5:0] m_bin;
  logic       s_clear, s_en, s_busy, s_rv;
  logic [5:0] s_bin;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic model_reset();
    m_fill = 0; m_settle = 0; m_cool = 0; m_clr = 0; m_rep = 0; m_bin = '0;
`ifdef DFSWT_SEQ_STATS_EN
    m_missed = 0;
`endif
  endtask

  // Drive one cycle's inputs, compare every output with the model, then advance one clock.
  task automatic step(input logic s, input logic e, input logic r, input logic [5:0] b, input logic rs);
    logic [9:0] got, exp;
    bit mb;
    sample_valid = s; event_detected = e; result_ready = r; freqbin_in = b; reset = rs;
    #2;
    if (!rs) model_reset();
    mb  = m_clr || (m_fill > 0) || (m_settle > 0) || m_rep || (m_cool > 0);
    exp = {mb, m_clr, (m_fill > 0) && s, m_rep, m_bin};
    got = {busy, dft_clear, dft_enable, result_valid, result_bin};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL cycle %0d busy/clr/en/rv/bin: got %b, expected %b", cyc_n, got, exp);
    {s_busy, s_clear, s_en, s_rv, s_bin} = got;
`ifdef DFSWT_SEQ_STATS_EN
    s_missed = int'(missed_events);
    chk($sformatf("cycle %0d missed_events", cyc_n), s_missed, m_missed);
    if (rs && mb && e && s && m_missed < 255) m_missed++;
`endif
    if (rs) begin
      if (m_clr) begin
        m_clr = 0; m_fill = WINDOW;
      end else if (m_fill > 0) begin
        if (s) begin
          m_fill--;
          if (m_fill == 0) m_settle = SETTLE;
        end
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin m_rep = 1; m_bin = b; end
      end else if (m_rep) begin
        if (r) begin m_rep = 0; m_cool = COOLDOWN; end
      end else if (m_cool > 0) begin
        if (s) m_cool--;
      end else if (e && s) begin
        m_clr = 1;
      end
    end
    @(posedge clock); #1;
    cyc_n++;
  endtask

  typedef struct {
    int ev_strobe; int ev2; int ready_delay; logic [5:0] bin;
    int exp_en; int exp_lat; int exp_rv; logic [5:0] exp_bin; int exp_missed;
  } row_t;
  row_t rows[3];

  initial begin
    rows[0] = '{10, 0,  0, 6'd17, 128, 515,  1, 6'd17, 0};
    rows[1] = '{10, 0, 50, 6'd17, 128, 515, 51, 6'd17, 0};
    rows[2] = '{ 3, 60, 5, 6'd42, 128, 515,  6, 6'd42, 1};
    model_reset();

    step(0, 0, 0, 6'd0, 0);
    step(0, 0, 0, 6'd0, 0);
    chk("reset outputs", int'({s_busy, s_clear, s_en, s_rv, s_bin}), 0);
    step(0, 0, 0, 6'd0, 1);

    for (int i = 0; i < 3; i++) begin
      int strobe, en_cnt, clr_cnt, rv_cnt, trig, rv_first, unstable, guard, c;
      logic [5:0] rv_bin, b;
      logic s, e, r;
      bit seen_busy, done;
      strobe = 0; en_cnt = 0; clr_cnt = 0; rv_cnt = 0; trig = 0; rv_first = 0;
      unstable = 0; guard = 0; rv_bin = '0; seen_busy = 0; done = 0;
      step(0, 0, 0, 6'd0, 0);
      step(0, 0, 0, 6'd0, 1);
      while (!done && guard < 3000) begin
        c = cyc_n;
        s = (cyc_n % 4 == 0);
        if (s) strobe++;
        e = s && ((strobe == rows[i].ev_strobe) ||
                  (rows[i].ev2 > 0 && clr_cnt > 0 && en_cnt == rows[i].ev2 - 1));
        r = (rv_cnt >= rows[i].ready_delay);
        b = (rv_cnt > 0) ? ~rows[i].bin : rows[i].bin;
        step(s, e, r, b, 1);
        guard++;
        if (e && strobe == rows[i].ev_strobe) trig = c;
        en_cnt  += int'(s_en);
        clr_cnt += int'(s_clear);
        if (s_rv) begin
          if (rv_cnt == 0) begin rv_first = c; rv_bin = s_bin; end
          else if (s_bin != rv_bin) unstable++;
          rv_cnt++;
        end
        if (s_busy) seen_busy = 1;
        else if (seen_busy) done = 1;
      end
      chk($sformatf("row%0d completed", i), int'(done), 1);
      chk($sformatf("row%0d clear pulses", i), clr_cnt, 1);
      chk($sformatf("row%0d enable pulses", i), en_cnt, rows[i].exp_en);
      chk($sformatf("row%0d latency", i), rv_first - trig, rows[i].exp_lat);
      chk($sformatf("row%0d result_valid cycles", i), rv_cnt, rows[i].exp_rv);
      chk($sformatf("row%0d result_bin", i), int'(rv_bin), int'(rows[i].exp_bin));
      chk($sformatf("row%0d result_bin changes while valid", i), unstable, 0);
`ifdef DFSWT_SEQ_STATS_EN
      chk($sformatf("row%0d missed_events", i), s_missed, rows[i].exp_missed);
`endif
    end

    // Cooldown: events on COOL strobes 5 and 16 ignored, strobe 17 re-arms.
    begin
      int k, guard, clr_cool, en;
      bit hs, trig_done;
      logic s, e;
      k = 0; guard = 0; clr_cool = 0; hs = 0; trig_done = 0;
      step(0, 0, 1, 6'd17, 0);
      step(0, 0, 1, 6'd17, 1);
      while (k < 17 && guard < 3000) begin
        s = (cyc_n % 4 == 0);
        if (hs && s) k++;
        e = s && (!trig_done || (hs && (k == 5 || k == 16 || k == 17)));
        if (e) trig_done = 1;
        step(s, e, 1, 6'd17, 1);
        guard++;
        if (hs && k < 17) clr_cool += int'(s_clear);
        if (s_rv) hs = 1;
      end
      chk("cooldown reached strobe 17", k, 17);
      chk("clear pulses during cooldown", clr_cool, 0);
      step(0, 0, 1, 6'd17, 1);
      chk("clear after cooldown", int'(s_clear), 1);

      // Abort on strobe 70 of FILL, then a fresh window must be complete.
      en = 0; guard = 0;
      while (en < 69 && guard < 1000) begin
        step(cyc_n % 4 == 0, 0, 1, 6'd17, 1);
        en += int'(s_en);
        guard++;
      end
      while (cyc_n % 4 != 0) step(0, 0, 1, 6'd17, 1);
      step(1, 0, 1, 6'd17, 0);
      chk("outputs under mid-fill reset", int'({s_busy, s_clear, s_en, s_rv, s_bin}), 0);
`ifdef DFSWT_SEQ_STATS_EN
      chk("missed_events under reset", s_missed, 0);
`endif
      step(0, 0, 1, 6'd17, 1);
      en = 0; guard = 0; trig_done = 0;
      while (!s_rv && guard < 1000) begin
        s = (cyc_n % 4 == 0);
        e = s && !trig_done;
        if (e) trig_done = 1;
        step(s, e, 1, 6'd17, 1);
        en += int'(s_en);
        guard++;
      end
      chk("window after abort saw result", int'(s_rv), 1);
      chk("enable pulses after abort", en, 128);
    end

`ifdef DFSWT_SEQ_STATS_EN
    step(0, 0, 1, 6'd0, 0);
    for (int i = 0; i < 400; i++) step(1, 1, 1, 6'd5, 1);
    chk("missed_events saturation", s_missed, 255);
`endif

    for (int i = 0; i < 4000; i++)
      step($urandom_range(2) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
           6'($urandom), $urandom_range(1499) != 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
